shifter_operand_decoder: RTL and testbench

Decode-stage block that turns the shifter-operand field of an ARM data-processing instruction into the operand set consumed by the barrel shifter: data, shift amount and shift operation. It handles the immediate, immediate-shift and register-shift addressing modes. It sequences Rm and Rs reads over the single shared register-file read port. Results are presented through a valid/ready handshake to the execute stage.

---
 rtl/shifter_operand_decoder.sv | 144 ++++++++++++++
 tb/tb_shifter_operand_decoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_operand_decoder.sv
// Decodes the ARM data-processing shifter operand into data, shift amount and shift op.
// Rm and Rs are read in turn over one shared register-file read port.
module shifter_operand_decoder #(
  parameter int unsigned OP_W       = 3,
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic                  flush,
  output logic [REG_ADDR_W-1:0] rf_raddr,
  input  logic [31:0]           rf_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [31:0]           out_shift_value,
  output logic [OP_W-1:0]       out_op_select
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FIELD_W = 12;

  localparam logic [OP_W-1:0] OP_LSL = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LSR = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ASR = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ROR = OP_W'(3);
  localparam logic [OP_W-1:0] OP_RRX = OP_W'(4);

  typedef enum logic [1:0] {IDLE, RD_RM, RD_RS, OUT} state_e;

  state_e                  state_q, state_d;
  logic [FIELD_W-1:0]      field_q, field_d;
  logic [REG_ADDR_W-1:0]   raddr_q, raddr_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [DATA_W-1:0]       shift_q, shift_d;
  logic [OP_W-1:0]         op_q, op_d;
  logic                    valid_q, valid_d;
  logic [4:0]              imm_amt;

  assign imm_amt = field_q[11:7];

  // State and operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      field_q <= '0;
      raddr_q <= '0;
      data_q  <= '0;
      shift_q <= '0;
      op_q    <= OP_LSL;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      raddr_q <= raddr_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and operand decode
  always_comb begin
    state_d = state_q;
    field_d = field_q;
    raddr_d = raddr_q;
    data_d  = data_q;
    shift_d = shift_q;
    op_d    = op_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            field_d = in_instr[FIELD_W-1:0];
            if (in_instr[25]) begin
              data_d  = DATA_W'(in_instr[7:0]);
              shift_d = DATA_W'({in_instr[11:8], 1'b0});
              op_d    = OP_ROR;
              state_d = OUT;
            end else begin
              raddr_d = in_instr[REG_ADDR_W-1:0];
              state_d = RD_RM;
            end
          end
        end
        RD_RM: begin
          data_d = rf_rdata;
          if (field_q[4]) begin
            op_d    = OP_W'(field_q[6:5]);
            raddr_d = field_q[8 +: REG_ADDR_W];
            state_d = RD_RS;
          end else begin
            state_d = OUT;
            // A zero amount means 32 for LSR/ASR and RRX for ROR
            case (field_q[6:5])
              2'b00: begin
                op_d    = OP_LSL;
                shift_d = DATA_W'(imm_amt);
              end
              2'b01: begin
                op_d    = OP_LSR;
                shift_d = (imm_amt == 5'd0) ? DATA_W'(32) : DATA_W'(imm_amt);
              end
              2'b10: begin
                op_d    = OP_ASR;
                shift_d = (imm_amt == 5'd0) ? DATA_W'(32) : DATA_W'(imm_amt);
              end
              default: begin
                op_d    = (imm_amt == 5'd0) ? OP_RRX : OP_ROR;
                shift_d = (imm_amt == 5'd0) ? DATA_W'(1) : DATA_W'(imm_amt);
              end
            endcase
          end
        end
        RD_RS: begin
          shift_d = DATA_W'(rf_rdata[7:0]);
          state_d = OUT;
        end
        OUT: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    valid_d = (state_d == OUT);
  end

  assign in_ready        = (state_q == IDLE);
  assign rf_raddr        = raddr_q;
  assign out_valid       = valid_q;
  assign out_data        = data_q;
  assign out_shift_value = shift_q;
  assign out_op_select   = op_q;

endmodule

// File: tb/tb_shifter_operand_decoder.sv
// Directed bench for shifter_operand_decoder with a behavioural register file.
module tb_shifter_operand_decoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic [3:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_shift_value;
  logic [2:0]  out_op_select;

  logic [31:0] rf [16];
  int          n_vec;
  int          n_err;

  shifter_operand_decoder #(.OP_W(3), .REG_ADDR_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .flush          (flush),
    .rf_raddr       (rf_raddr),
    .rf_rdata       (rf_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_shift_value(out_shift_value),
    .out_op_select  (out_op_select)
  );

  assign rf_rdata = rf[rf_raddr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one instruction, wait for the operand set, check it, then retire it.
  task automatic run(input string tag, input logic [31:0] instr, input int lat,
                     input logic [31:0] e_data, input logic [31:0] e_shift,
                     input logic [2:0] e_op);
    int cyc;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_instr = instr;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_instr = 32'hFFFF_FFFF;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      step();
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(lat));
    chk({tag, ".data"}, out_data, e_data);
    chk({tag, ".shift"}, out_shift_value, e_shift);
    chk({tag, ".op"}, 32'(out_op_select), 32'(e_op));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".retire_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".retire_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".hold_data"}, out_data, e_data);
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    n_vec     = 0;
    n_err     = 0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h1111_0000 + 32'(i);
    rf[1] = 32'hF000_0000;
    rf[2] = 32'h8000_0001;
    rf[3] = 32'h1234_0120;
    rf[4] = 32'h0000_0100;

    step();
    step();
    rst = 1'b0;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.data", out_data, 32'd0);
    chk("reset.shift", out_shift_value, 32'd0);
    chk("reset.op", 32'(out_op_select), 32'd0);
    chk("reset.raddr", 32'(rf_raddr), 32'd0);

    run("imm_4_ff", 32'h0200_04FF, 1, 32'h0000_00FF, 32'd8, 3'b011);
    run("imm_0_00", 32'h0200_0000, 1, 32'h0000_0000, 32'd0, 3'b011);
    run("imm_f_5a", 32'h0200_0F5A, 1, 32'h0000_005A, 32'd30, 3'b011);

    run("lsr0", 32'h0000_0022, 2, 32'h8000_0001, 32'd32, 3'b001);
    run("ror0", 32'h0000_0062, 2, 32'h8000_0001, 32'd1, 3'b100);
    run("lsl0", 32'h0000_0002, 2, 32'h8000_0001, 32'd0, 3'b000);
    run("ror5", 32'h0000_02E2, 2, 32'h8000_0001, 32'd5, 3'b011);
    run("asr0", 32'h0000_0041, 2, 32'hF000_0000, 32'd32, 3'b010);
    run("asr31", 32'h0000_0FC2, 2, 32'h8000_0001, 32'd31, 3'b010);

    // Register shift with read-port address sequencing
    in_instr = 32'h0000_0351;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_instr = '0;
    chk("regasr.raddr_rm", 32'(rf_raddr), 32'd1);
    chk("regasr.valid_rm", 32'(out_valid), 32'd0);
    step();
    chk("regasr.raddr_rs", 32'(rf_raddr), 32'd3);
    chk("regasr.valid_rs", 32'(out_valid), 32'd0);
    step();
    chk("regasr.valid", 32'(out_valid), 32'd1);
    chk("regasr.data", out_data, 32'hF000_0000);
    chk("regasr.shift", out_shift_value, 32'h0000_0020);
    chk("regasr.op", 32'(out_op_select), 32'd2);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("regasr.raddr_hold", 32'(rf_raddr), 32'd3);

    run("reglsr_zero", 32'h0000_0432, 3, 32'h8000_0001, 32'd0, 3'b001);
    run("regror", 32'h0000_0371, 3, 32'hF000_0000, 32'h20, 3'b011);

    // Backpressure: hold out_ready low for five cycles
    in_instr = 32'h0200_04FF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_instr = 32'h0200_0F00;
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", 32'(out_valid), 32'd1);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.data", out_data, 32'h0000_00FF);
      chk("bp.shift", out_shift_value, 32'd8);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp.release_valid", 32'(out_valid), 32'd0);
    chk("bp.release_ready", 32'(in_ready), 32'd1);

    // Flush in RD_RS drops the instruction
    in_instr = 32'h0000_0351;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_rs.valid", 32'(out_valid), 32'd0);
    chk("flush_rs.in_ready", 32'(in_ready), 32'd1);
    step();
    step();
    chk("flush_rs.no_emit", 32'(out_valid), 32'd0);

    // Reset while in OUT
    in_instr = 32'h0200_04FF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rst_out.pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_out.valid", 32'(out_valid), 32'd0);
    chk("rst_out.data", out_data, 32'd0);
    chk("rst_out.op", 32'(out_op_select), 32'd0);
    chk("rst_out.in_ready", 32'(in_ready), 32'd1);
    run("after_rst_imm", 32'h0200_0A3C, 1, 32'h0000_003C, 32'd20, 3'b011);

    // Flush coinciding with accept: instruction dropped
    in_instr = 32'h0200_04FF;
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_acc.in_ready", 32'(in_ready), 32'd1);
    chk("flush_acc.valid", 32'(out_valid), 32'd0);
    step();
    chk("flush_acc.no_emit", 32'(out_valid), 32'd0);

    // Flush in OUT with out_ready high
    in_instr = 32'h0200_0111;
    in_valid = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    out_ready = 1'b0;
    flush     = 1'b0;
    chk("flush_out.valid", 32'(out_valid), 32'd0);
    chk("flush_out.in_ready", 32'(in_ready), 32'd1);

    // Back-to-back immediates with in_valid and out_ready held high
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_instr  = 32'h0200_0103;
    step();
    chk("b2b0.valid", 32'(out_valid), 32'd1);
    chk("b2b0.data", out_data, 32'h0000_0003);
    chk("b2b0.shift", out_shift_value, 32'd2);
    in_instr = 32'h0200_0213;
    step();
    chk("b2b0.gap", 32'(out_valid), 32'd0);
    chk("b2b0.in_ready", 32'(in_ready), 32'd1);
    step();
    chk("b2b1.valid", 32'(out_valid), 32'd1);
    chk("b2b1.data", out_data, 32'h0000_0013);
    chk("b2b1.shift", out_shift_value, 32'd4);
    in_instr = 32'h0200_0323;
    step();
    chk("b2b1.gap", 32'(out_valid), 32'd0);
    chk("b2b1.in_ready", 32'(in_ready), 32'd1);
    step();
    chk("b2b2.valid", 32'(out_valid), 32'd1);
    chk("b2b2.data", out_data, 32'h0000_0023);
    chk("b2b2.shift", out_shift_value, 32'd6);
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("b2b2.gap", 32'(out_valid), 32'd0);
    step();
    chk("b2b.drained", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
